sample_collector: RTL and testbench

Receiving end of the sample feeder's isValid/received handshake. It accepts NUM_SAMPLES words of SAMPLE_SIZE*DATA_SIZE bits, one per handshake, and packs them into a flat buffer. Sample 0 is stored in the LSBs, matching the feeder's indexing. When the buffer is full it raises done, and holds done until the consumer acknowledges it. The block sits downstream of the feeder (or any equivalent producer) and feeds the compute stage that needs the whole sample set.

---
 rtl/sample_pkg.sv | 15 +
 rtl/sample_collector_FSM.sv | 74 +++++++
 rtl/sample_collector.sv | 64 ++++++
 tb/tb_sample_collector.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared definitions for the sample feeder/collector pair.
package sample_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_COLLECT = 2'b01,
      ST_FULL    = 2'b10
   } collector_state_t;

   function automatic int unsigned sample_width(input int unsigned sample_size,
                                                input int unsigned data_size);
      return sample_size * data_size;
   endfunction

endpackage

// File: rtl/sample_collector_FSM.sv
// Control FSM for sample_collector: handshake accept, count clear and done flag.
module sample_collector_FSM
   import sample_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic isValid,
   input  logic lastAccept,
   input  logic consume,
   output logic received,
   output logic wrEn,
   output logic clearCount,
   output logic done
);

   collector_state_t r_state;
   logic             r_done;
   logic             w_received;
   logic             w_clearCount;

   always_comb begin
      w_received   = 1'b0;
      w_clearCount = 1'b0;
      case (r_state)
         ST_IDLE:    w_clearCount = enable;
         ST_COLLECT: w_received   = isValid & enable;
         ST_FULL:    w_clearCount = consume & enable;
         default:    ;
      endcase
      // Reset must silence the handshake even before the state register clears.
      if (!rst) begin
         w_received   = 1'b0;
         w_clearCount = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable) r_state <= ST_COLLECT;
            end
            ST_COLLECT: begin
               if (!enable) begin
                  r_state <= ST_IDLE;
               end else if (w_received && lastAccept) begin
                  r_state <= ST_FULL;
                  r_done  <= 1'b1;
               end
            end
            ST_FULL: begin
               if (consume) begin
                  r_state <= enable ? ST_COLLECT : ST_IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign received   = w_received;
   assign wrEn       = w_received;
   assign clearCount = w_clearCount;
   assign done       = r_done;

endmodule

// File: rtl/sample_collector.sv
// Collects NUM_SAMPLES handshaked words into a flat buffer, sample 0 in the LSBs.
module sample_collector
   import sample_pkg::*;
#(
   parameter  int NUM_SAMPLES = 1,
   parameter  int SAMPLE_SIZE = 4,
   parameter  int DATA_SIZE   = 4,
   localparam int W           = int'(sample_width(SAMPLE_SIZE, DATA_SIZE)),
   localparam int CW          = $clog2(NUM_SAMPLES) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [W-1:0]             inSample,
   input  logic                     isValid,
   output logic                     received,
   output logic [NUM_SAMPLES*W-1:0] samples,
   output logic [CW-1:0]            count,
   output logic                     done,
   input  logic                     consume
);

   localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES - 1);

   logic [CW-1:0]            r_count;
   logic [NUM_SAMPLES*W-1:0] r_samples;
   logic                     w_lastAccept;
   logic                     w_wrEn;
   logic                     w_clearCount;

   assign w_lastAccept = (r_count == LAST);

   sample_collector_FSM u_fsm (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .isValid    (isValid),
      .lastAccept (w_lastAccept),
      .consume    (consume),
      .received   (received),
      .wrEn       (w_wrEn),
      .clearCount (w_clearCount),
      .done       (done)
   );

   // Slots are not cleared on a new set; each is overwritten on its own accept.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count   <= '0;
         r_samples <= '0;
      end else if (w_clearCount) begin
         r_count <= '0;
      end else if (w_wrEn) begin
         r_count <= r_count + CW'(1);
         for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
            if (r_count == CW'(i)) r_samples[i*W +: W] <= inSample;
         end
      end
   end

   assign samples = r_samples;
   assign count   = r_count;

endmodule

// File: tb/tb_sample_collector.sv
// Randomized scoreboard bench for sample_collector against a set-level reference model.
module tb_sample_collector;

   localparam int N  = 3;
   localparam int W  = 16;
   localparam int CW = 3;

   localparam int M_IDLE = 0, M_COLLECT = 1, M_FULL = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           enable = 1'b0;
   logic           isValid = 1'b0;
   logic           consume = 1'b0;
   logic [W-1:0]   inSample = '0;
   logic           received;
   logic           done;
   logic [N*W-1:0] samples;
   logic [CW-1:0]  count;

   always #5 clk = ~clk;

   sample_collector #(
      .NUM_SAMPLES (N),
      .SAMPLE_SIZE (4),
      .DATA_SIZE   (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .inSample (inSample),
      .isValid  (isValid),
      .received (received),
      .samples  (samples),
      .count    (count),
      .done     (done),
      .consume  (consume)
   );

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   int           m_mode = M_IDLE;
   int           m_cnt  = 0;
   logic [W-1:0] m_slot [N];
   logic [N*W-1:0] sb [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N*W-1:0] m_packed();
      logic [N*W-1:0] p;
      for (int i = 0; i < N; i++) p[i*W +: W] = m_slot[i];
      return p;
   endfunction

   task automatic step(input logic r, input logic en, input logic v,
                       input logic [W-1:0] d, input logic c);
      @(negedge clk);
      rst = r; enable = en; isValid = v; inSample = d; consume = c;
      #1;
      chk("received", 64'(received), 64'(r && m_mode == M_COLLECT && en && v));
      @(posedge clk);
      if (!r) begin
         m_mode = M_IDLE;
         m_cnt  = 0;
         for (int i = 0; i < N; i++) m_slot[i] = '0;
      end else begin
         case (m_mode)
            M_IDLE: if (en) begin m_cnt = 0; m_mode = M_COLLECT; end
            M_COLLECT: begin
               if (!en) m_mode = M_IDLE;
               else if (v) begin
                  m_slot[m_cnt] = d;
                  m_cnt++;
                  if (m_cnt == N) begin
                     m_mode = M_FULL;
                     sb.push_back(m_packed());
                  end
               end
            end
            default: if (c) begin
               if (en) begin m_cnt = 0; m_mode = M_COLLECT; end
               else m_mode = M_IDLE;
            end
         endcase
      end
      #1;
      chk("done", 64'(done), 64'(m_mode == M_FULL));
      chk("count", 64'(count), 64'(m_cnt));
      chk("samples", 64'(samples), 64'(m_packed()));
   endtask

   // Monitor: each completed set is checked when done rises.
   initial begin
      logic prev = 1'b0;
      logic [N*W-1:0] exp;
      forever begin
         @(negedge clk);
         if (done === 1'b1 && prev !== 1'b1) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL sb_unexpected_done: got done=1 required no pending set at %0t", $time);
            end else begin
               exp = sb.pop_front();
               chk("sb_samples", 64'(samples), 64'(exp));
               chk("sb_count", 64'(count), 64'(N));
            end
         end
         prev = done;
      end
   end

   initial begin
      logic r, en, v, c;
      for (int i = 0; i < N; i++) m_slot[i] = '0;
      step(0, 0, 0, '0, 0);
      step(0, 0, 0, '0, 0);
      // Basic set, then back-pressure while FULL.
      step(1, 1, 0, '0, 0);
      step(1, 1, 1, 16'h1234, 0);
      step(1, 1, 1, 16'hABCD, 0);
      step(1, 1, 1, 16'h00FF, 0);
      chk("basic_set", 64'(samples), 64'h00FF_ABCD_1234);
      for (int i = 0; i < 5; i++) step(1, 1, 1, 16'hDEAD, 0);
      step(1, 0, 1, 16'hDEAD, 0);
      // Consume with enable high: next set starts at once.
      step(1, 1, 0, '0, 1);
      // Abort then restart.
      step(1, 1, 1, 16'h1111, 0);
      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 0);
      step(1, 1, 0, '0, 0);
      step(1, 1, 1, 16'h2222, 0);
      step(1, 1, 1, 16'h3333, 0);
      step(1, 1, 1, 16'h4444, 0);
      chk("abort_set", 64'(samples), 64'h4444_3333_2222);
      // Consume with enable low: back to IDLE.
      step(1, 0, 0, '0, 1);
      step(1, 0, 1, 16'h5555, 0);
      // Reset mid-set.
      step(1, 1, 0, '0, 0);
      step(1, 1, 1, 16'hAAAA, 0);
      step(1, 1, 1, 16'hBBBB, 0);
      step(0, 1, 1, 16'hCCCC, 0);
      step(1, 1, 1, 16'hDDDD, 0);
      step(1, 1, 1, 16'hEEEE, 0);
      step(1, 1, 1, 16'hFFFF, 0);
      step(1, 1, 1, 16'h0123, 0);
      // Random traffic, including a feeder-like producer that is valid every other cycle.
      for (int i = 0; i < 2000; i++) begin
         r  = ($urandom_range(0, 199) != 0);
         en = ($urandom_range(0, 15) != 0);
         v  = (i < 400) ? 1'(i % 2) : 1'($urandom_range(0, 3) != 0);
         c  = ($urandom_range(0, 4) == 0);
         step(r, en, v, W'($urandom), c);
      end
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 0);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
